// File: rtl/npc_uart_axil_pkg.sv
// npc_uart_axil_pkg: register map, AXI response codes and serializer states shared by the UART.
package npc_uart_axil_pkg;
    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;
endpackage

// File: rtl/npc_sync_fifo.sv
// npc_sync_fifo: single-clock FIFO with occupancy count; pointers wrap modulo DEPTH.
module npc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    // Storage needs no reset: the count alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
    assign dout = mem_q[rd_ptr_q];
    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/npc_uart_axil.sv
// npc_uart_axil: AXI4-Lite slave feeding a TX FIFO and an 8N1 serializer on txd.
module npc_uart_axil
    import npc_uart_axil_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        txd
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    ser_state_e state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, head;
    logic [CNT_W-1:0] count;
    logic wr_tx, rd_status, wr_hs, rd_hs, push, pop, full, empty, busy, div_done;
    logic unused_bits;
    assign unused_bits = ^{awaddr[31:4], araddr[31:4], wdata[31:8], wstrb[3:1], count};
    npc_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .din(wdata[7:0]),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    // Ready outputs are gated by reset so they read low while reset is held.
    always_comb begin
        wr_tx = awaddr[3:0] == REG_TXDATA;
        rd_status = araddr[3:0] == REG_STATUS;
        wr_hs = !reset && awvalid && wvalid && !bvalid_q && (!wr_tx || !full);
        rd_hs = arvalid && arready;
        push = wr_hs && wr_tx && wstrb[0];
        bvalid_d = wr_hs || (bvalid_q && !bready);
        bresp_d = wr_hs ? (wr_tx ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        rvalid_d = rd_hs || (rvalid_q && !rready);
        rdata_d = rd_hs ? (rd_status ? {29'b0, busy, empty, full} : 32'b0) : rdata_q;
        rresp_d = rd_hs ? (rd_status ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    end
    assign awready = wr_hs;
    assign wready = wr_hs;
    assign arready = !reset && !rvalid_q;
    assign bvalid = bvalid_q;
    assign bresp = bresp_q;
    assign rvalid = rvalid_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    always_comb begin
        busy = state_q != S_IDLE;
        div_done = div_q == DIV_W'(CLK_DIV - 1);
        pop = state_q == S_IDLE && !empty;
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        div_d = (state_q == S_IDLE || div_done) ? '0 : div_q + 1'b1;
        case (state_q)
            S_IDLE: if (!empty) begin
                state_d = S_START;
                shift_d = head;
            end
            S_START: if (div_done) begin
                state_d = S_DATA;
                bit_d = '0;
            end
            S_DATA: if (div_done) begin
                shift_d = shift_q >> 1;
                bit_d = bit_q + 1'b1;
                state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
            end
            S_STOP: if (div_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    assign txd = state_q == S_START ? 1'b0 : state_q == S_DATA ? shift_q[0] : 1'b1;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bvalid_q <= 1'b0;
            bresp_q <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
            state_q <= S_IDLE;
            div_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            state_q <= state_d;
            div_q <= div_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
        end
    end
endmodule
